fpu_result_pack: RTL and testbench



---
 rtl/fpu_result_pack_pkg.sv | 67 ++++++
 rtl/fpu_result_pack_if.sv | 42 ++++
 rtl/fpu_result_pack_skid_buffer.sv | 83 ++++++++
 rtl/fpu_result_pack.sv | 99 +++++++++
 tb/tb_fpu_result_pack.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fpu_result_pack_pkg.sv
// Shared types for the FPU result-pack stage.
//   fpu_result_pack_pkg : skid-buffer state encoding
//   fpu_format          : default field widths and the float_t word layout
//   sign / exponent / fraction_msb / fraction_lsbs : per-field select codes
//                         produced by the decode/special-case stage
package fpu_result_pack_pkg;
  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_HOLD  = 2'd1,
    BUF_FULL  = 2'd2
  } buf_state_e;
endpackage

package fpu_format;
  localparam int unsigned EXP_WIDTH  = 8;
  localparam int unsigned FRAC_WIDTH = 23;

  typedef struct packed {
    logic                  sign;
    logic [EXP_WIDTH-1:0]  exponent;
    logic [FRAC_WIDTH-1:0] fraction;
  } float_t;
endpackage

package sign;
  typedef enum logic [2:0] {
    ZERO   = 3'd0,
    ONE    = 3'd1,
    A      = 3'd2,
    B      = 3'd3,
    NB     = 3'd4,
    A_B    = 3'd5,
    A_NB   = 3'd6,
    RESULT = 3'd7
  } sign_select;
endpackage

package exponent;
  typedef enum logic [2:0] {
    ZEROS    = 3'd0,
    ONES     = 3'd1,
    A        = 3'd2,
    B        = 3'd3,
    RESULT   = 3'd4,
    DONTCARE = 3'd5
  } exponent_select;
endpackage

package fraction_msb;
  typedef enum logic [2:0] {
    ZERO     = 3'd0,
    ONE      = 3'd1,
    A        = 3'd2,
    B        = 3'd3,
    RESULT   = 3'd4,
    DONTCARE = 3'd5
  } fraction_msb_select;
endpackage

package fraction_lsbs;
  typedef enum logic [1:0] {
    ZEROS  = 2'd0,
    A      = 2'd1,
    B      = 2'd2,
    RESULT = 2'd3
  } fraction_lsbs_select;
endpackage

// File: rtl/fpu_result_pack_if.sv
// Bus between the select-generation stage, the result-pack stage and the
// FPU result port.
//   Input side : in_valid/in_ready, operands a/b, computed result fields,
//                four field select codes
//   Output side: out_valid/out_ready, out_result {sign, exponent, fraction}
// master = the environment driving operands and consuming results,
// slave  = fpu_result_pack.
interface fpu_result_pack_if #(
  parameter int unsigned EXP_WIDTH  = fpu_format::EXP_WIDTH,
  parameter int unsigned FRAC_WIDTH = fpu_format::FRAC_WIDTH
);
  localparam int unsigned WIDTH = 1 + EXP_WIDTH + FRAC_WIDTH;

  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH-1:0]      a;
  logic [WIDTH-1:0]      b;
  logic                  result_sign;
  logic [EXP_WIDTH-1:0]  result_exponent;
  logic [FRAC_WIDTH-1:0] result_fraction;
  logic [2:0]            sign_sel;
  logic [2:0]            exponent_sel;
  logic [2:0]            fraction_msb_sel;
  logic [1:0]            fraction_lsbs_sel;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      out_result;

  modport master (
    output in_valid, a, b, result_sign, result_exponent, result_fraction,
           sign_sel, exponent_sel, fraction_msb_sel, fraction_lsbs_sel,
           out_ready,
    input  in_ready, out_valid, out_result
  );

  modport slave (
    input  in_valid, a, b, result_sign, result_exponent, result_fraction,
           sign_sel, exponent_sel, fraction_msb_sel, fraction_lsbs_sel,
           out_ready,
    output in_ready, out_valid, out_result
  );
endinterface

// File: rtl/fpu_result_pack_skid_buffer.sv
// Two-entry skid buffer: an output register plus one skid register.
//   in_valid/in_ready/in_data    : upstream handshake; in_ready is a flop
//   out_valid/out_ready/out_data : downstream handshake; out_data is a flop
// Reset (async, active-low) empties both entries and clears out_data.
module skid_buffer
  import fpu_result_pack_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);
  buf_state_e       state_q, state_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             accept;
  logic             emit;

  assign accept = in_valid && in_ready_q;
  assign emit   = out_valid_q && out_ready;

  always_comb begin
    state_d    = state_q;
    out_data_d = out_data_q;
    skid_d     = skid_q;
    case (state_q)
      BUF_EMPTY: begin
        if (accept) begin
          out_data_d = in_data;
          state_d    = BUF_HOLD;
        end
      end
      BUF_HOLD: begin
        if (accept && emit) begin
          out_data_d = in_data;
        end else if (accept) begin
          skid_d  = in_data;
          state_d = BUF_FULL;
        end else if (emit) begin
          state_d = BUF_EMPTY;
        end
      end
      BUF_FULL: begin
        // in_ready is low here, so only the drain of the skid word can happen.
        if (emit) begin
          out_data_d = skid_q;
          state_d    = BUF_HOLD;
        end
      end
      default: state_d = BUF_EMPTY;
    endcase
    in_ready_d  = (state_d != BUF_FULL);
    out_valid_d = (state_d != BUF_EMPTY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= BUF_EMPTY;
      out_data_q  <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
endmodule

// File: rtl/fpu_result_pack.sv
// Final FPU stage: assembles the IEEE-754 result word from per-field selects
// (constant, operand A, operand B or computed result) and registers it
// behind a 2-entry skid buffer.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus (slave)  : input handshake + operands/result fields/select codes,
//                  output handshake + packed result word
// Undefined select codes produce 0 in their field.
module fpu_result_pack #(
  parameter int unsigned EXP_WIDTH  = fpu_format::EXP_WIDTH,
  parameter int unsigned FRAC_WIDTH = fpu_format::FRAC_WIDTH
) (
  input  logic               clk,
  input  logic               reset_n,
  fpu_result_pack_if.slave   bus
);
  localparam int unsigned WIDTH = 1 + EXP_WIDTH + FRAC_WIDTH;

  // Width-generic view of an operand; matches fpu_format::float_t at defaults.
  typedef struct packed {
    logic                  sign;
    logic [EXP_WIDTH-1:0]  exponent;
    logic [FRAC_WIDTH-1:0] fraction;
  } word_t;

  word_t                 op_a, op_b;
  logic                  sign_f;
  logic [EXP_WIDTH-1:0]  exp_f;
  logic                  msb_f;
  logic [FRAC_WIDTH-2:0] lsbs_f;
  logic [WIDTH-1:0]      packed_word;

  assign op_a = bus.a;
  assign op_b = bus.b;

  always_comb begin
    sign_f = 1'b0;
    case (sign::sign_select'(bus.sign_sel))
      sign::ZERO:   sign_f = 1'b0;
      sign::ONE:    sign_f = 1'b1;
      sign::A:      sign_f = op_a.sign;
      sign::B:      sign_f = op_b.sign;
      sign::NB:     sign_f = ~op_b.sign;
      sign::A_B:    sign_f = op_a.sign ^ op_b.sign;
      sign::A_NB:   sign_f = op_a.sign ^ ~op_b.sign;
      sign::RESULT: sign_f = bus.result_sign;
      default:      sign_f = 1'b0;
    endcase
  end

  always_comb begin
    exp_f = '0;
    case (exponent::exponent_select'(bus.exponent_sel))
      exponent::ZEROS:  exp_f = '0;
      exponent::ONES:   exp_f = '1;
      exponent::A:      exp_f = op_a.exponent;
      exponent::B:      exp_f = op_b.exponent;
      exponent::RESULT: exp_f = bus.result_exponent;
      default:          exp_f = '0;
    endcase
  end

  always_comb begin
    msb_f = 1'b0;
    case (fraction_msb::fraction_msb_select'(bus.fraction_msb_sel))
      fraction_msb::ZERO:   msb_f = 1'b0;
      fraction_msb::ONE:    msb_f = 1'b1;
      fraction_msb::A:      msb_f = op_a.fraction[FRAC_WIDTH-1];
      fraction_msb::B:      msb_f = op_b.fraction[FRAC_WIDTH-1];
      fraction_msb::RESULT: msb_f = bus.result_fraction[FRAC_WIDTH-1];
      default:              msb_f = 1'b0;
    endcase
  end

  always_comb begin
    lsbs_f = '0;
    case (fraction_lsbs::fraction_lsbs_select'(bus.fraction_lsbs_sel))
      fraction_lsbs::ZEROS:  lsbs_f = '0;
      fraction_lsbs::A:      lsbs_f = op_a.fraction[FRAC_WIDTH-2:0];
      fraction_lsbs::B:      lsbs_f = op_b.fraction[FRAC_WIDTH-2:0];
      fraction_lsbs::RESULT: lsbs_f = bus.result_fraction[FRAC_WIDTH-2:0];
      default:               lsbs_f = '0;
    endcase
  end

  assign packed_word = {sign_f, exp_f, msb_f, lsbs_f};

  skid_buffer #(
    .WIDTH(WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst_n     (reset_n),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   (packed_word),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_data  (bus.out_result)
  );
endmodule

// File: tb/tb_fpu_result_pack.sv
module tb_fpu_result_pack;
  import fpu_format::*;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  fpu_result_pack_if #(.EXP_WIDTH(EXP_WIDTH), .FRAC_WIDTH(FRAC_WIDTH)) bus ();

  fpu_result_pack #(
    .EXP_WIDTH (EXP_WIDTH),
    .FRAC_WIDTH(FRAC_WIDTH)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int          checks     = 0;
  int          failures   = 0;
  int          emit_count = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference: each field chosen from a table of candidates indexed by its code.
  function automatic logic [31:0] ref_pack(input float_t a, input float_t b,
                                           input logic rs, input logic [7:0] re,
                                           input logic [22:0] rf,
                                           input int unsigned ss, input int unsigned es,
                                           input int unsigned ms, input int unsigned ls);
    float_t      r;
    logic [7:0]  sign_opts;
    int unsigned msb;
    int unsigned lsbs;
    int unsigned low_mod;
    low_mod   = 1 << (FRAC_WIDTH - 1);
    sign_opts = {rs, a.sign ^ ~b.sign, a.sign ^ b.sign, ~b.sign, b.sign, a.sign, 1'b1, 1'b0};
    r.sign    = sign_opts[ss];
    case (es)
      1:       r.exponent = 8'((2 ** EXP_WIDTH) - 1);
      2:       r.exponent = a.exponent;
      3:       r.exponent = b.exponent;
      4:       r.exponent = re;
      default: r.exponent = 8'd0;
    endcase
    case (ms)
      1:       msb = 1;
      2:       msb = int'(a.fraction) / low_mod;
      3:       msb = int'(b.fraction) / low_mod;
      4:       msb = int'(rf) / low_mod;
      default: msb = 0;
    endcase
    case (ls)
      1:       lsbs = int'(a.fraction) % low_mod;
      2:       lsbs = int'(b.fraction) % low_mod;
      3:       lsbs = int'(rf) % low_mod;
      default: lsbs = 0;
    endcase
    r.fraction = 23'(msb * low_mod + lsbs);
    return r;
  endfunction

  // Input side of the scoreboard: every accepted word queues its expectation.
  always @(negedge clk) begin
    if (reset_n && bus.in_valid && bus.in_ready)
      exp_q.push_back(ref_pack(bus.a, bus.b, bus.result_sign, bus.result_exponent,
                               bus.result_fraction, bus.sign_sel, bus.exponent_sel,
                               bus.fraction_msb_sel, bus.fraction_lsbs_sel));
  end

  // Output monitor: pops on every emit, and checks stability under stall.
  logic        stall_prev = 1'b0;
  logic [31:0] stall_word = '0;
  always @(negedge clk) begin
    if (reset_n) begin
      if (stall_prev && bus.out_valid)
        check("stable_under_stall", bus.out_result, stall_word);
      if (bus.out_valid && bus.out_ready) begin
        emit_count++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output actual=%h required=no_output", bus.out_result);
        end else begin
          check("scoreboard", bus.out_result, exp_q.pop_front());
        end
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      stall_word = bus.out_result;
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic rand_fields();
    bus.a                 = $urandom;
    bus.b                 = $urandom;
    bus.result_sign       = 1'($urandom);
    bus.result_exponent   = 8'($urandom);
    bus.result_fraction   = 23'($urandom);
    bus.sign_sel          = 3'($urandom);
    bus.exponent_sel      = 3'($urandom);
    bus.fraction_msb_sel  = 3'($urandom);
    bus.fraction_lsbs_sel = 2'($urandom);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (n) step();
  endtask

  int e0;

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    rand_fields();
    #1 reset_n = 1'b0;
    repeat (2) step();
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_out_result", bus.out_result, 32'd0);
    check("reset_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    step();
    check("post_reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("post_reset_out_result", bus.out_result, 32'd0);
    check("post_reset_in_ready", 32'(bus.in_ready), 32'd1);

    // Quiet NaN from constants.
    rand_fields();
    bus.sign_sel          = sign::ZERO;
    bus.exponent_sel      = exponent::ONES;
    bus.fraction_msb_sel  = fraction_msb::ONE;
    bus.fraction_lsbs_sel = fraction_lsbs::ZEROS;
    bus.in_valid          = 1'b1;
    bus.out_ready         = 1'b1;
    step();
    bus.in_valid = 1'b0;
    check("qnan_valid", 32'(bus.out_valid), 32'd1);
    check("qnan_word", bus.out_result, 32'h7FC00000);
    idle(2);

    // Sign from A xor B, remaining fields from the computed result.
    bus.a                 = 32'h80000000;
    bus.b                 = 32'h3F800000;
    bus.result_sign       = 1'b0;
    bus.result_exponent   = 8'h7F;
    bus.result_fraction   = 23'h0;
    bus.sign_sel          = sign::A_B;
    bus.exponent_sel      = exponent::RESULT;
    bus.fraction_msb_sel  = fraction_msb::RESULT;
    bus.fraction_lsbs_sel = fraction_lsbs::RESULT;
    bus.in_valid          = 1'b1;
    step();
    bus.in_valid = 1'b0;
    check("a_b_valid", 32'(bus.out_valid), 32'd1);
    check("a_b_word", bus.out_result, 32'hBF800000);
    idle(2);

    // Stall: three back-to-back offers, only two fit.
    bus.out_ready = 1'b0;
    e0 = emit_count;
    for (int i = 0; i < 3; i++) begin
      rand_fields();
      bus.in_valid = 1'b1;
      step();
      if (i == 0) check("stall_in_ready_after_first", 32'(bus.in_ready), 32'd1);
      else        check("stall_in_ready_low", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid = 1'b0;
    check("stall_queued", 32'(exp_q.size()), 32'd2);
    bus.out_ready = 1'b1;
    repeat (3) step();
    check("stall_drained", 32'(emit_count - e0), 32'd2);
    check("stall_in_ready_back", 32'(bus.in_ready), 32'd1);
    check("stall_out_valid_low", 32'(bus.out_valid), 32'd0);

    // Full-rate stream.
    idle(2);
    e0 = emit_count;
    for (int i = 0; i < 100; i++) begin
      rand_fields();
      bus.in_valid = 1'b1;
      if (i % 10 == 0) check("stream_in_ready", 32'(bus.in_ready), 32'd1);
      step();
    end
    bus.in_valid = 1'b0;
    step();
    check("stream_count", 32'(emit_count - e0), 32'd100);
    check("stream_empty", 32'(exp_q.size()), 32'd0);

    // Random handshakes on both sides.
    for (int i = 0; i < 10000; i++) begin
      rand_fields();
      bus.in_valid  = 1'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    idle(5);
    check("random_drained", 32'(exp_q.size()), 32'd0);

    // Reset while FULL.
    idle(2);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rand_fields();
      bus.in_valid = 1'b1;
      step();
    end
    bus.in_valid = 1'b0;
    check("full_before_reset", 32'(bus.in_ready), 32'd0);
    #2 reset_n = 1'b0;
    exp_q.delete();
    #1;
    check("async_reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("async_reset_out_result", bus.out_result, 32'd0);
    check("async_reset_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    step();
    reset_n       = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("after_reset_no_output", 32'(bus.out_valid), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
